// File: rtl/mcs4_rom_busif_if.sv
// CPU-side and program-memory-side signal bundle for mcs4_rom_busif; ROM_IO_EN adds the I/O port pins.
// The slave modport is the ROM bus interface, the master modport is the CPU/memory environment.
interface mcs4_rom_busif_if;
   logic       step;
   logic       sync;
   logic [3:0] d_in;
   logic       cm_rom;
   logic [3:0] bank_hi;
   logic [7:0] pm_data;
   logic [3:0] d_out;
   logic       d_oe;
   logic [7:0] bank;
   logic [7:0] romaddr;
   logic [3:0] phase;
   logic       fetch_done;
`ifdef ROM_IO_EN
   logic [3:0] io_port;
   logic [3:0] io_in;
`endif

   modport slave (
`ifdef ROM_IO_EN
      input  io_in,
      output io_port,
`endif
      input  step, sync, d_in, cm_rom, bank_hi, pm_data,
      output d_out, d_oe, bank, romaddr, phase, fetch_done
   );

   modport master (
`ifdef ROM_IO_EN
      output io_in,
      input  io_port,
`endif
      output step, sync, d_in, cm_rom, bank_hi, pm_data,
      input  d_out, d_oe, bank, romaddr, phase, fetch_done
   );
endinterface

// File: rtl/mcs4_rom_busif.sv
// MCS-4 ROM bus phase tracker: latches the 12-bit address, returns opcode nibbles, optional ROM I/O via ROM_IO_EN.
// Outputs are registered one clk after the step strobe; no backpressure, the CPU paces everything with step.
module mcs4_rom_busif (
   input  logic           clk,
   input  logic           reset,
   mcs4_rom_busif_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      A1   = 4'd1,
      A2   = 4'd2,
      A3   = 4'd3,
      M1   = 4'd4,
      M2   = 4'd5,
      X1   = 4'd6,
      X2   = 4'd7,
      X3   = 4'd8
   } phase_t;

   phase_t     phase_q, phase_d;
   logic [3:0] a1_q, a1_d;
   logic [3:0] a2_q, a2_d;
   logic [3:0] a3_q, a3_d;
   logic [7:0] romaddr_q, romaddr_d;
   logic [7:0] bank_q, bank_d;
   logic [3:0] d_out_q, d_out_d;
   logic       d_oe_q, d_oe_d;
   logic       fetch_done_q, fetch_done_d;
   logic [3:0] opa_q, opa_d;
   logic       io_pending_q, io_pending_d;
`ifdef ROM_IO_EN
   logic [3:0] src_chip_q, src_chip_d;
   logic [3:0] io_port_q, io_port_d;
   logic       chip_sel;
`endif

`ifdef ROM_IO_EN
   // I/O instructions only act when the last SRC addressed this ROM's chip number (a3).
   assign chip_sel = io_pending_q && (src_chip_q == a3_q);
`endif

   always_comb begin
      phase_d      = phase_q;
      a1_d         = a1_q;
      a2_d         = a2_q;
      a3_d         = a3_q;
      romaddr_d    = romaddr_q;
      bank_d       = bank_q;
      d_out_d      = d_out_q;
      d_oe_d       = d_oe_q;
      fetch_done_d = 1'b0;
      opa_d        = opa_q;
      io_pending_d = io_pending_q;
`ifdef ROM_IO_EN
      src_chip_d   = src_chip_q;
      io_port_d    = io_port_q;
`endif
      if (bus.step) begin
         // Every step ends the current drive window unless the new phase drives again.
         d_oe_d = 1'b0;
         if (bus.sync) begin
            phase_d      = A1;
            io_pending_d = 1'b0;
         end else begin
            case (phase_q)
               IDLE: begin
                  phase_d      = IDLE;
                  io_pending_d = 1'b0;
               end
               A1: begin
                  a1_d    = bus.d_in;
                  phase_d = A2;
               end
               A2: begin
                  a2_d    = bus.d_in;
                  phase_d = A3;
               end
               A3: begin
                  a3_d      = bus.d_in;
                  romaddr_d = {a2_q, a1_q};
                  bank_d    = {bus.bank_hi, bus.d_in};
                  d_out_d   = bus.pm_data[7:4];
                  d_oe_d    = 1'b1;
                  phase_d   = M1;
               end
               M1: begin
                  d_out_d = bus.pm_data[3:0];
                  d_oe_d  = 1'b1;
                  phase_d = M2;
               end
               M2: begin
                  opa_d        = d_out_q;
                  fetch_done_d = 1'b1;
                  io_pending_d = io_pending_q | bus.cm_rom;
                  phase_d      = X1;
               end
               X1: begin
`ifdef ROM_IO_EN
                  if (chip_sel && (opa_q == 4'hA)) begin
                     d_out_d = bus.io_in;
                     d_oe_d  = 1'b1;
                  end
`endif
                  phase_d = X2;
               end
               X2: begin
`ifdef ROM_IO_EN
                  if (chip_sel && (opa_q == 4'h2)) begin
                     io_port_d = bus.d_in;
                  end
                  if (bus.cm_rom) begin
                     src_chip_d = bus.d_in;
                  end
`endif
                  phase_d = X3;
               end
               X3: begin
                  phase_d      = IDLE;
                  io_pending_d = 1'b0;
               end
               default: begin
                  phase_d      = IDLE;
                  io_pending_d = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q      <= IDLE;
         a1_q         <= 4'h0;
         a2_q         <= 4'h0;
         a3_q         <= 4'h0;
         romaddr_q    <= 8'h00;
         bank_q       <= 8'h00;
         d_out_q      <= 4'h0;
         d_oe_q       <= 1'b0;
         fetch_done_q <= 1'b0;
         opa_q        <= 4'h0;
         io_pending_q <= 1'b0;
`ifdef ROM_IO_EN
         src_chip_q   <= 4'h0;
         io_port_q    <= 4'h0;
`endif
      end else begin
         phase_q      <= phase_d;
         a1_q         <= a1_d;
         a2_q         <= a2_d;
         a3_q         <= a3_d;
         romaddr_q    <= romaddr_d;
         bank_q       <= bank_d;
         d_out_q      <= d_out_d;
         d_oe_q       <= d_oe_d;
         fetch_done_q <= fetch_done_d;
         opa_q        <= opa_d;
         io_pending_q <= io_pending_d;
`ifdef ROM_IO_EN
         src_chip_q   <= src_chip_d;
         io_port_q    <= io_port_d;
`endif
      end
   end

   assign bus.phase      = phase_q;
   assign bus.d_out      = d_out_q;
   assign bus.d_oe       = d_oe_q;
   assign bus.romaddr    = romaddr_q;
   assign bus.bank       = bank_q;
   assign bus.fetch_done = fetch_done_q;
`ifdef ROM_IO_EN
   assign bus.io_port    = io_port_q;
`endif

endmodule

// File: doc/mcs4_rom_busif.md
MCS4_ROM_BUSIF -- requirements
Module: mcs4_rom_busif

Interface
REQ-001 SHALL have these ports (clock and reset first):
- clk  in  1  single system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- step  in  1  one-clk strobe; advances the bus phase by one
- sync  in  1  CPU SYNC; when high with step, next phase is A1
- d_in  in  4  CPU data bus nibble
- cm_rom  in  1  CPU CM-ROM line
- bank_hi  in  4  upper bank bits from the external bank-select register
- pm_data  in  8  program-memory read byte for {bank, romaddr}
- d_out  out  4  nibble driven to the CPU bus
- d_oe  out  1  d_out valid/drive enable
- bank  out  8  program-memory bank = {bank_hi, A3 nibble}
- romaddr  out  8  program-memory byte address = {A2, A1}
- phase  out  4  current bus phase (encoding in REQ-005)
- fetch_done  out  1  one-clk pulse when the M2 phase completes

Function
REQ-005 SHALL run a phase FSM with encoding IDLE=0, A1=1, A2=2, A3=3, M1=4, M2=5, X1=6, X2=7, X3=8; no change when step=0.
REQ-006 On step: sync=1 -> A1 from any state; else A1..X2 -> next phase; X3 -> IDLE (sync lost); IDLE stays IDLE.
REQ-007 On step in A1/A2/A3, d_in SHALL be latched into shadow nibbles a1/a2/a3 respectively.
REQ-008 romaddr and bank SHALL update together, only on the step leaving A3: romaddr={a2,a1}, bank={bank_hi,a3}; hold otherwise (no partial address visible).
REQ-009 On the step entering M1: d_out<=pm_data[7:4], d_oe<=1; entering M2: d_out<=pm_data[3:0], d_oe<=1 (registered, one clk after step).
REQ-010 On the step leaving M2: d_oe<=0, fetch_done=1 for exactly one clk; the M2 nibble is also kept internally as opa.
REQ-011 cm_rom sampled on the step leaving M2 SHALL set io_pending (I/O instruction), cleared on the step entering A1 or IDLE.
REQ-012 d_oe SHALL be 0 in IDLE, A1-A3, X1, X3 and whenever the FSM leaves a cycle early via sync.
REQ-013 sync asserted mid-cycle (e.g. in M1) SHALL abort: next phase A1, d_oe<=0, no fetch_done, romaddr/bank unchanged.
REQ-014 step and reset in the same clk: reset wins.

Reset
REQ-015 reset SHALL force phase=IDLE, d_out=0, d_oe=0, romaddr=0, bank=0, fetch_done=0, a1/a2/a3=0, opa=0, io_pending=0, and (with macro) io_port=0, src_chip=0.
REQ-016 Reset mid-cycle SHALL discard the cycle; next fetch requires sync+step.

Configuration
REQ-017 Macro ROM_IO_EN SHALL enable ROM I/O port support; when undefined, io_port/io_in/src_chip logic and ports are absent and X2 behaves as a plain phase.
REQ-018 With ROM_IO_EN, ports: io_port out 4 (latched WRR data), io_in in 4 (port pins for RDR), plus internal src_chip[3:0].
REQ-019 With ROM_IO_EN, on step leaving X2 with cm_rom=1: src_chip<=d_in (SRC).
REQ-020 With ROM_IO_EN, io_pending=1 and src_chip==a3 on step leaving X2: opa=4'h2 (WRR) -> io_port<=d_in; on step entering X2 with opa=4'hA (RDR): d_out<=io_in, d_oe<=1, cleared on leaving X2.

Verification
REQ-021 reset, then sync+step, step x8 with d_in A1=5,A2=3,A3=2, pm_data=8'hD4 -> romaddr=8'h35, bank={bank_hi,4'h2}, d_out=D in M1, 4 in M2, one fetch_done pulse.
REQ-022 Back-to-back cycles with sync at X3 -> no IDLE between, phase 8->1; without sync at X3 -> phase 0, d_oe stays 0.
REQ-023 sync+step while in M1 -> phase=1, d_oe=0, no fetch_done, romaddr unchanged.
REQ-024 reset asserted in M2 with step -> all outputs 0, phase=0 next clk.
REQ-025 ROM_IO_EN: SRC chip 2 (cm_rom at X2, d_in=2), then fetch with a3=2, opa=2, cm_rom at M2, X2 d_in=9 -> io_port=9; same with a3=3 -> io_port unchanged.
REQ-026 ROM_IO_EN: RDR (opa=4'hA, io_pending, src_chip==a3), io_in=6 -> d_out=6, d_oe=1 during X2 only.
